// File: rtl/vec_alu_result_collector.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : vec_alu_result_collector                                      |
// | Brief    : joins two ALU half-results into a tagged vector and queues it |
// |            in a writeback FIFO drained over valid/ready.                 |
// |            Optional macro WB_BYPASS_EN: zero-latency empty-FIFO bypass.  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module vec_alu_result_collector #(
  parameter int LANE_W     = 8,
  parameter int LANES      = 4,
  parameter int REG_ADDR_W = 4,
  parameter int DEPTH      = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        alu_start,
  input  logic [REG_ADDR_W-1:0]       dest_reg,
  input  logic                        out_en1,
  input  logic                        out_en2,
  input  logic                        alu_rdy,
  input  logic [LANES*LANE_W-1:0]     lane_res,
  output logic                        issue_ok,
  output logic                        wb_valid,
  input  logic                        wb_ready,
  output logic [REG_ADDR_W-1:0]       wb_addr,
  output logic [2*LANES*LANE_W-1:0]   wb_data,
  output logic                        err_seq,
  output logic                        err_ovf
);

  localparam int c_half_w = LANES * LANE_W;
  localparam int c_vec_w  = 2 * c_half_w;
  localparam int c_ent_w  = REG_ADDR_W + c_vec_w;
  localparam int c_ptr_w  = $clog2(DEPTH);
  localparam int c_cnt_w  = c_ptr_w + 1;
  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_LO  = 2'd1,
    S_WAIT_HI  = 2'd2,
    S_WAIT_RDY = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    w_seq_err;
  logic                    w_latch_dest;
  logic                    w_cap_lo;
  logic                    w_cap_hi;
  logic                    w_push_req;
  logic [3:0]              w_ev;

  logic [REG_ADDR_W-1:0]   r_dest;
  logic [c_half_w-1:0]     r_lo;
  logic [c_half_w-1:0]     r_hi;

  logic [c_ent_w-1:0]      r_mem [DEPTH];
  logic [c_ptr_w-1:0]      r_wr_ptr;
  logic [c_ptr_w-1:0]      r_rd_ptr;
  logic [c_cnt_w-1:0]      r_count;
  logic [c_ent_w-1:0]      w_push_ent;
  logic [c_ent_w-1:0]      w_head;
  logic                    w_empty;
  logic                    w_full;
  logic                    w_bypass;
  logic                    w_pop;
  logic                    w_wr;
  logic                    w_rd;
  logic                    w_ovf;
  logic [c_cnt_w:0]        w_occ;
  logic                    r_err_seq;
  logic                    r_err_ovf;

  // Every event is checked against the single one-hot pattern the state expects.
  assign w_ev = {alu_start, out_en1, out_en2, alu_rdy};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_seq_err    = 1'b0;
    w_latch_dest = 1'b0;
    w_cap_lo     = 1'b0;
    w_cap_hi     = 1'b0;
    w_push_req   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|w_ev[2:0]) begin
          w_seq_err = 1'b1;
        end else if (alu_start) begin
          w_latch_dest = 1'b1;
          w_state_nxt  = S_WAIT_LO;
        end
      end
      S_WAIT_LO: begin
        if (w_ev == 4'b0100) begin
          w_cap_lo    = 1'b1;
          w_state_nxt = S_WAIT_HI;
        end else if (|w_ev) begin
          w_seq_err   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT_HI: begin
        if (w_ev == 4'b0010) begin
          w_cap_hi    = 1'b1;
          w_state_nxt = S_WAIT_RDY;
        end else if (|w_ev) begin
          w_seq_err   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      S_WAIT_RDY: begin
        if (w_ev == 4'b0001) begin
          w_push_req  = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (|w_ev) begin
          w_seq_err   = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_dest <= '0;
      r_lo   <= '0;
      r_hi   <= '0;
    end else begin
      if (w_latch_dest) r_dest <= dest_reg;
      if (w_cap_lo)     r_lo   <= lane_res;
      if (w_cap_hi)     r_hi   <= lane_res;
    end
  end

  assign w_push_ent = {r_dest, r_hi, r_lo};
  assign w_head     = r_mem[r_rd_ptr];
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == c_depth);

`ifdef WB_BYPASS_EN
  assign w_bypass = w_push_req & w_empty;
`else
  assign w_bypass = 1'b0;
`endif

  assign wb_valid             = ~w_empty | w_bypass;
  assign {wb_addr, wb_data}   = w_bypass ? w_push_ent : w_head;
  assign w_pop                = wb_valid & wb_ready;
  // A bypassed entry taken in its own cycle never touches the storage.
  assign w_wr  = w_push_req & (~w_full | w_pop) & ~(w_bypass & wb_ready);
  assign w_rd  = w_pop & ~w_empty;
  assign w_ovf = w_push_req & w_full & ~w_pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr) begin
      r_mem[r_wr_ptr] <= w_push_ent;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_err_seq <= 1'b0;
      r_err_ovf <= 1'b0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      r_count <= r_count + c_cnt_w'(w_wr) - c_cnt_w'(w_rd);
      if (w_seq_err) r_err_seq <= 1'b1;
      if (w_ovf)     r_err_ovf <= 1'b1;
    end
  end

  // An op in flight reserves a slot so a full pipeline can never overflow.
  assign w_occ    = {1'b0, r_count} + {{c_cnt_w{1'b0}}, (r_state != S_IDLE)};
  assign issue_ok = (w_occ < {1'b0, c_depth});
  assign err_seq  = r_err_seq;
  assign err_ovf  = r_err_ovf;

endmodule
`default_nettype wire
